// File: rtl/gpu_clock_div_ctrl.sv
// Runtime-programmable 50% duty clock divider with tick output.
// Divisor and enable changes are held until a period boundary.
module gpu_clock_div_ctrl #(
  parameter int DIV_W   = 8,
  parameter int MAX_DIV = 254
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_enable,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             div_tick,
  output logic             running,
  output logic [DIV_W-1:0] cur_div
);

  if ((MAX_DIV % 2) != 0 || MAX_DIV < 2 ||
      MAX_DIV >= (1 << DIV_W)) begin : g_bad_max
    $fatal(1, "MAX_DIV must be even, >=2, <2**DIV_W");
  end

  localparam logic [1:0] S_STOP = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SW   = 2'd2;

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
  localparam logic [DIV_W-1:0] MAX_D = DIV_W'(MAX_DIV);

  logic [1:0]       st, st_n;
  logic [DIV_W-1:0] count, cnt_n;
  logic [DIV_W-1:0] div_n;
  logic             pend_en, pend_en_n;
  logic [DIV_W-1:0] pend_div, pend_div_n;

  logic             acc, legal, req_ok, wrap;
  logic             do_apply, app_en;
  logic [DIV_W-1:0] app_div;
  logic             live_n;

  assign acc    = cfg_valid & cfg_ready;
  assign legal  = ~cfg_enable |
                  (~cfg_div[0] & (cfg_div >= TWO) &
                   (cfg_div <= MAX_D));
  assign req_ok = acc & legal;
  assign wrap   = (count == (cur_div - ONE));

  // Next-state decode: count advance, request latch, boundary apply
  always_comb begin
    st_n       = st;
    cnt_n      = count;
    div_n      = cur_div;
    pend_en_n  = pend_en;
    pend_div_n = pend_div;
    do_apply   = 1'b0;
    app_en     = cfg_enable;
    app_div    = cfg_div;
    unique case (st)
      S_STOP: begin
        if (req_ok && cfg_enable) begin
          do_apply = 1'b1;
        end
      end
      S_RUN: begin
        if (wrap) begin
          cnt_n    = '0;
          do_apply = req_ok;
        end else begin
          cnt_n = count + ONE;
          if (req_ok) begin
            st_n       = S_SW;
            pend_en_n  = cfg_enable;
            pend_div_n = cfg_div;
          end
        end
      end
      S_SW: begin
        app_en  = pend_en;
        app_div = pend_div;
        if (wrap) begin
          do_apply = 1'b1;
        end else begin
          cnt_n = count + ONE;
        end
      end
      default: begin
        st_n  = S_STOP;
        cnt_n = '0;
        div_n = '0;
      end
    endcase
    if (do_apply) begin
      cnt_n = '0;
      if (app_en) begin
        st_n  = S_RUN;
        div_n = app_div;
      end else begin
        st_n  = S_STOP;
        div_n = '0;
      end
    end
  end

  assign live_n = (st_n != S_STOP);

  // State and registered outputs; reset clears everything at once
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      st        <= S_STOP;
      count     <= '0;
      cur_div   <= '0;
      pend_en   <= 1'b0;
      pend_div  <= '0;
      div_clk   <= 1'b0;
      div_tick  <= 1'b0;
      cfg_err   <= 1'b0;
      running   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      st        <= st_n;
      count     <= cnt_n;
      cur_div   <= div_n;
      pend_en   <= pend_en_n;
      pend_div  <= pend_div_n;
      div_clk   <= live_n & (cnt_n < (div_n >> 1));
      div_tick  <= live_n & (cnt_n == '0);
      cfg_err   <= acc & ~legal;
      running   <= live_n;
      cfg_ready <= (st_n != S_SW);
    end
  end

endmodule

// File: tb/tb_gpu_clock_div_ctrl.sv
// Bench for gpu_clock_div_ctrl: directed literal cases plus
// randomized requests checked against a period-level model.
module tb_gpu_clock_div_ctrl;
  localparam int DW = 8;
  localparam int MD = 20;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_enable;
  logic [DW-1:0] cfg_div;
  logic          cfg_err;
  logic          div_clk;
  logic          div_tick;
  logic          running;
  logic [DW-1:0] cur_div;

  gpu_clock_div_ctrl #(.DIV_W(DW), .MAX_DIV(MD)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_enable (cfg_enable),
    .cfg_div    (cfg_div),
    .cfg_err    (cfg_err),
    .div_clk    (div_clk),
    .div_tick   (div_tick),
    .running    (running),
    .cur_div    (cur_div)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: m_div = divisor in effect (0 = stopped), m_pos = cycle in period
  int m_div, m_pos, m_pdiv;
  bit m_pv, m_pen, m_err;

  always @(posedge clk_in or posedge rst) begin
    bit acc, legal, bnd, hreq, ren;
    int rdiv;
    if (rst) begin
      m_div = 0; m_pos = 0; m_pv = 0; m_pen = 0; m_pdiv = 0; m_err = 0;
    end else begin
      acc   = cfg_valid && !m_pv;
      legal = !cfg_enable ||
              (cfg_div % 2 == 0 && cfg_div >= 2 && cfg_div <= MD);
      m_err = acc && !legal;
      if (m_div == 0) begin
        if (acc && legal && cfg_enable) begin
          m_div = int'(cfg_div);
          m_pos = 0;
        end
      end else begin
        bnd  = (m_pos == m_div - 1);
        hreq = m_pv || (acc && legal);
        ren  = m_pv ? m_pen : cfg_enable;
        rdiv = m_pv ? m_pdiv : int'(cfg_div);
        if (bnd && hreq) begin
          m_pv  = 0;
          m_div = ren ? rdiv : 0;
          m_pos = 0;
        end else begin
          if (hreq && !m_pv) begin
            m_pv = 1; m_pen = ren; m_pdiv = rdiv;
          end
          m_pos = (m_pos + 1) % m_div;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk_in) begin
    if (cmp_en && !rst) begin
      chk("div_clk", int'(div_clk), int'(m_div != 0 && m_pos < m_div / 2));
      chk("div_tick", int'(div_tick), int'(m_div != 0 && m_pos == 0));
      chk("running", int'(running), int'(m_div != 0));
      chk("cur_div", int'(cur_div), m_div);
      chk("cfg_ready", int'(cfg_ready), int'(!m_pv));
      chk("cfg_err", int'(cfg_err), int'(m_err));
    end
  end

  task automatic drive(input bit v, input bit en, input int d);
    cfg_valid  = v;
    cfg_enable = en;
    cfg_div    = DW'(d);
  endtask

  task automatic reset_zero_check(input string tag);
    chk({tag, "_clk"}, int'(div_clk), 0);
    chk({tag, "_tick"}, int'(div_tick), 0);
    chk({tag, "_run"}, int'(running), 0);
    chk({tag, "_div"}, int'(cur_div), 0);
    chk({tag, "_err"}, int'(cfg_err), 0);
    chk({tag, "_rdy"}, int'(cfg_ready), 1);
  endtask

  initial begin
    int clk_a[4];
    int tck_a[4];
    int six[6];
    int bad[3];
    bit seen;
    clk_a = '{1, 0, 0, 1};
    tck_a = '{0, 0, 0, 1};
    six   = '{1, 1, 1, 0, 0, 0};
    bad   = '{5, 0, 22};
    rst = 1'b1;
    drive(0, 0, 0);
    #12;
    reset_zero_check("reset");
    @(negedge clk_in);
    rst = 1'b0;
    cmp_en = 1'b1;

    // start at divide-by-4
    @(negedge clk_in);
    drive(1, 1, 4);
    @(negedge clk_in);
    drive(0, 0, 0);
    chk("t1_first_clk", int'(div_clk), 1);
    chk("t1_first_tick", int'(div_tick), 1);
    chk("t1_cur_div", int'(cur_div), 4);
    chk("t1_running", int'(running), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("t1_clk_seq", int'(div_clk), clk_a[i]);
      chk("t1_tick_seq", int'(div_tick), tck_a[i]);
    end

    // request divide-by-2 on the last cycle of a period
    repeat (3) @(negedge clk_in);
    drive(1, 1, 2);
    @(negedge clk_in);
    drive(0, 0, 0);
    chk("t6_clk0", int'(div_clk), 1);
    chk("t6_tick0", int'(div_tick), 1);
    chk("t6_div", int'(cur_div), 2);
    chk("t6_ready", int'(cfg_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("t6_clk_seq", int'(div_clk), (i % 2 == 0) ? 0 : 1);
    end

    // back to 4, then switch to 6 mid-period
    drive(1, 1, 4);
    @(negedge clk_in);
    drive(0, 0, 0);
    chk("t2_div4", int'(cur_div), 4);
    @(negedge clk_in);
    drive(1, 1, 6);
    @(negedge clk_in);
    drive(0, 0, 0);
    chk("t2_rdy_lo1", int'(cfg_ready), 0);
    chk("t2_olddiv", int'(cur_div), 4);
    @(negedge clk_in);
    chk("t2_rdy_lo2", int'(cfg_ready), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk("t2_clk6", int'(div_clk), six[i]);
      if (i == 0) begin
        chk("t2_tick6", int'(div_tick), 1);
        chk("t2_rdy_back", int'(cfg_ready), 1);
        chk("t2_div6", int'(cur_div), 6);
      end
    end

    // illegal divisors: odd, zero, above MAX_DIV
    foreach (bad[k]) begin
      drive(1, 1, bad[k]);
      @(negedge clk_in);
      drive(0, 0, 0);
      chk("t3_err", int'(cfg_err), 1);
      chk("t3_div_kept", int'(cur_div), 6);
      @(negedge clk_in);
      chk("t3_err_clr", int'(cfg_err), 0);
    end

    // async reset while div_clk is high
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_in);
      seen = div_clk;
    end
    chk("t5_saw_high", int'(seen), 1);
    #1 rst = 1'b1;
    #1;
    reset_zero_check("t5_async");
    @(negedge clk_in);
    rst = 1'b0;

    // randomized requests
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 599) == 0) begin
        drive(0, 0, 0);
        #1 rst = 1'b1;
        #1;
        reset_zero_check("rnd_async");
        @(negedge clk_in);
        rst = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        int d;
        bit en;
        en = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 255);
        else d = 2 * $urandom_range(1, MD / 2);
        drive(1, en, d);
      end else begin
        drive(0, 0, 0);
      end
    end
    @(negedge clk_in);
    drive(0, 0, 0);
    repeat (2) @(negedge clk_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
